// File: rtl/pic_host_bus_controller.sv
// Bus master for an 8259-style PIC: runs the ICW init sequence, single
// OCW writes / status reads, and the two-pulse INTA acknowledge cycle with
// the returned vector held in a valid/ready buffer.
module pic_host_bus_controller #(
    parameter int STROBE_CYCLES = 2,
    parameter int GAP_CYCLES    = 1
) (
    input  logic       clk,
    input  logic       reset,
    // ICW configuration request
    input  logic       cfg_start,
    input  logic [7:0] cfg_icw1,
    input  logic [7:0] cfg_icw2,
    input  logic [7:0] cfg_icw3,
    input  logic [7:0] cfg_icw4,
    output logic       cfg_busy,
    output logic       cfg_done,
    // single register access
    input  logic       reg_wr_req,
    input  logic       reg_rd_req,
    input  logic       reg_a0,
    input  logic [7:0] reg_wr_data,
    output logic       reg_ready,
    output logic [7:0] reg_rd_data,
    output logic       reg_rd_valid,
    // interrupt acknowledge
    input  logic       INT,
    input  logic       int_enable,
    output logic [7:0] vec_data,
    output logic       vec_valid,
    input  logic       vec_ready,
    // PIC pins
    input  logic [7:0] data_in,
    output logic [7:0] data_out,
    output logic       data_oe,
    output logic       A0,
    output logic       chip_select_n,
    output logic       write_n,
    output logic       read_n,
    output logic       inta_n
);

    typedef enum logic [3:0] {
        IDLE, W_SETUP, W_STROBE, W_HOLD, R_STROBE, R_RECOV, A1, AGAP, A2, A_DONE
    } state_t;

    // The shared counter only ever holds (length - 1) of the longest phase.
    localparam int CNT_MAX = (STROBE_CYCLES > GAP_CYCLES) ? STROBE_CYCLES : GAP_CYCLES;
    localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
    localparam logic [CNT_W-1:0] STROBE_LOAD = CNT_W'(STROBE_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_LOAD    = CNT_W'(GAP_CYCLES - 1);

    state_t           state_reg, state_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic             cnt_zero;

    logic             cs_n_reg, write_n_reg, read_n_reg, inta_n_reg, data_oe_reg;
    logic             cs_n_next, write_n_next, read_n_next, inta_n_next, data_oe_next;

    logic [7:0]       data_out_reg;
    logic             a0_reg;
    logic             cfg_busy_reg, cfg_done_reg;
    logic [7:0]       reg_rd_data_reg;
    logic             reg_rd_valid_reg;
    logic [7:0]       vec_data_reg;
    logic             vec_valid_reg;

    logic [1:0]       icw_idx_reg;
    logic [1:0]       icw_nidx;
    logic             icw_more;
    logic [7:0]       cfg_icw_in [4];
    logic [7:0]       icw_bytes  [4];

    logic             int_req;
    logic             accept_cfg, accept_int, accept_wr, accept_rd;

    assign int_req    = INT && int_enable && !vec_valid_reg;
    assign accept_cfg = (state_reg == IDLE) && cfg_start;
    assign accept_int = (state_reg == IDLE) && !cfg_start && int_req;
    assign reg_ready  = (state_reg == IDLE) && !cfg_start && !int_req;
    assign accept_wr  = reg_ready && reg_wr_req;
    assign accept_rd  = reg_ready && reg_rd_req && !reg_wr_req;
    assign cnt_zero   = (cnt_reg == '0);

    assign cfg_icw_in[0] = cfg_icw1;
    assign cfg_icw_in[1] = cfg_icw2;
    assign cfg_icw_in[2] = cfg_icw3;
    assign cfg_icw_in[3] = cfg_icw4;

    // ICW byte bank, captured once when the configuration request is accepted
    for (genvar gi = 0; gi < 4; gi++) begin : g_icw
        logic [7:0] byte_reg;
        // Latch one ICW byte on acceptance
        always_ff @(posedge clk) begin
            if (reset) begin
                byte_reg <= '0;
            end else if (accept_cfg) begin
                byte_reg <= cfg_icw_in[gi];
            end
        end
        assign icw_bytes[gi] = byte_reg;
    end

    // Select the next ICW: ICW3 only in cascade mode, ICW4 only when IC4 is set
    always_comb begin
        icw_more = 1'b0;
        icw_nidx = icw_idx_reg;
        case (icw_idx_reg)
            2'd0: begin
                icw_more = 1'b1;
                icw_nidx = 2'd1;
            end
            2'd1: begin
                if (!icw_bytes[0][1]) begin
                    icw_more = 1'b1;
                    icw_nidx = 2'd2;
                end else if (icw_bytes[0][0]) begin
                    icw_more = 1'b1;
                    icw_nidx = 2'd3;
                end
            end
            2'd2: begin
                if (icw_bytes[0][0]) begin
                    icw_more = 1'b1;
                    icw_nidx = 2'd3;
                end
            end
            default: ;
        endcase
    end

    // State and phase counter register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= IDLE;
            cnt_reg   <= '0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
        end
    end

    // Next-state logic with fixed-priority arbitration in IDLE
    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_zero ? cnt_reg : cnt_reg - 1'b1;
        case (state_reg)
            IDLE: begin
                if (accept_cfg || accept_wr) begin
                    state_next = W_SETUP;
                end else if (accept_int) begin
                    state_next = A1;
                    cnt_next   = STROBE_LOAD;
                end else if (accept_rd) begin
                    state_next = R_STROBE;
                    cnt_next   = STROBE_LOAD;
                end
            end
            W_SETUP: begin
                state_next = W_STROBE;
                cnt_next   = STROBE_LOAD;
            end
            W_STROBE: if (cnt_zero) state_next = W_HOLD;
            W_HOLD:   state_next = (cfg_busy_reg && icw_more) ? W_SETUP : IDLE;
            R_STROBE: if (cnt_zero) state_next = R_RECOV;
            R_RECOV:  state_next = IDLE;
            A1: begin
                if (cnt_zero) begin
                    state_next = AGAP;
                    cnt_next   = GAP_LOAD;
                end
            end
            AGAP: begin
                if (cnt_zero) begin
                    state_next = A2;
                    cnt_next   = STROBE_LOAD;
                end
            end
            A2:       if (cnt_zero) state_next = A_DONE;
            A_DONE:   state_next = IDLE;
            default:  state_next = IDLE;
        endcase
    end

    // Pin levels decoded from the upcoming state so the pins register with it
    always_comb begin
        cs_n_next    = 1'b1;
        write_n_next = 1'b1;
        read_n_next  = 1'b1;
        inta_n_next  = 1'b1;
        data_oe_next = 1'b0;
        case (state_next)
            W_SETUP, W_HOLD: begin
                cs_n_next    = 1'b0;
                data_oe_next = 1'b1;
            end
            W_STROBE: begin
                cs_n_next    = 1'b0;
                write_n_next = 1'b0;
                data_oe_next = 1'b1;
            end
            R_STROBE: begin
                cs_n_next   = 1'b0;
                read_n_next = 1'b0;
            end
            A1, A2:  inta_n_next = 1'b0;
            default: ;
        endcase
    end

    // Registered strobes: glitch-free pins, forced inactive by reset
    always_ff @(posedge clk) begin
        if (reset) begin
            cs_n_reg    <= 1'b1;
            write_n_reg <= 1'b1;
            read_n_reg  <= 1'b1;
            inta_n_reg  <= 1'b1;
            data_oe_reg <= 1'b0;
        end else begin
            cs_n_reg    <= cs_n_next;
            write_n_reg <= write_n_next;
            read_n_reg  <= read_n_next;
            inta_n_reg  <= inta_n_next;
            data_oe_reg <= data_oe_next;
        end
    end

    // Address/data, ICW sequencing, read capture and the vector buffer
    always_ff @(posedge clk) begin
        if (reset) begin
            data_out_reg     <= '0;
            a0_reg           <= 1'b0;
            cfg_busy_reg     <= 1'b0;
            cfg_done_reg     <= 1'b0;
            icw_idx_reg      <= '0;
            reg_rd_data_reg  <= '0;
            reg_rd_valid_reg <= 1'b0;
            vec_data_reg     <= '0;
            vec_valid_reg    <= 1'b0;
        end else begin
            cfg_done_reg     <= 1'b0;
            reg_rd_valid_reg <= 1'b0;

            if (accept_cfg) begin
                cfg_busy_reg <= 1'b1;
                icw_idx_reg  <= 2'd0;
                data_out_reg <= cfg_icw1;
                a0_reg       <= 1'b0;
            end else if (accept_wr) begin
                data_out_reg <= reg_wr_data;
                a0_reg       <= reg_a0;
            end else if (accept_rd) begin
                a0_reg       <= reg_a0;
            end

            if (state_reg == W_HOLD && cfg_busy_reg) begin
                if (icw_more) begin
                    icw_idx_reg  <= icw_nidx;
                    data_out_reg <= icw_bytes[icw_nidx];
                    a0_reg       <= 1'b1;
                end else begin
                    cfg_busy_reg <= 1'b0;
                    cfg_done_reg <= 1'b1;
                end
            end

            if (state_reg == R_STROBE && cnt_zero) begin
                reg_rd_data_reg  <= data_in;
                reg_rd_valid_reg <= 1'b1;
            end

            // Buffer is empty whenever A2 runs, so vec_data never moves while valid
            if (state_reg == A2 && cnt_zero) begin
                vec_data_reg <= data_in;
            end

            if (vec_valid_reg && vec_ready) begin
                vec_valid_reg <= 1'b0;
            end else if (state_reg == A_DONE) begin
                vec_valid_reg <= 1'b1;
            end
        end
    end

    assign chip_select_n = cs_n_reg;
    assign write_n       = write_n_reg;
    assign read_n        = read_n_reg;
    assign inta_n        = inta_n_reg;
    assign data_oe       = data_oe_reg;
    assign data_out      = data_out_reg;
    assign A0            = a0_reg;
    assign cfg_busy      = cfg_busy_reg;
    assign cfg_done      = cfg_done_reg;
    assign reg_rd_data   = reg_rd_data_reg;
    assign reg_rd_valid  = reg_rd_valid_reg;
    assign vec_data      = vec_data_reg;
    assign vec_valid     = vec_valid_reg;

endmodule

// File: tb/tb_pic_host_bus_controller.sv
// Directed bench for pic_host_bus_controller at default timing (S=2, G=1).
module tb_pic_host_bus_controller;

    logic       clk = 1'b0;
    logic       reset;
    logic       cfg_start;
    logic [7:0] cfg_icw1, cfg_icw2, cfg_icw3, cfg_icw4;
    logic       cfg_busy, cfg_done;
    logic       reg_wr_req, reg_rd_req, reg_a0;
    logic [7:0] reg_wr_data;
    logic       reg_ready;
    logic [7:0] reg_rd_data;
    logic       reg_rd_valid;
    logic       INT, int_enable;
    logic [7:0] vec_data;
    logic       vec_valid, vec_ready;
    logic [7:0] data_in, data_out;
    logic       data_oe, A0, chip_select_n, write_n, read_n, inta_n;

    always #5 clk = ~clk;

    pic_host_bus_controller dut (
        .clk(clk), .reset(reset),
        .cfg_start(cfg_start), .cfg_icw1(cfg_icw1), .cfg_icw2(cfg_icw2),
        .cfg_icw3(cfg_icw3), .cfg_icw4(cfg_icw4),
        .cfg_busy(cfg_busy), .cfg_done(cfg_done),
        .reg_wr_req(reg_wr_req), .reg_rd_req(reg_rd_req), .reg_a0(reg_a0),
        .reg_wr_data(reg_wr_data), .reg_ready(reg_ready),
        .reg_rd_data(reg_rd_data), .reg_rd_valid(reg_rd_valid),
        .INT(INT), .int_enable(int_enable),
        .vec_data(vec_data), .vec_valid(vec_valid), .vec_ready(vec_ready),
        .data_in(data_in), .data_out(data_out), .data_oe(data_oe), .A0(A0),
        .chip_select_n(chip_select_n), .write_n(write_n), .read_n(read_n),
        .inta_n(inta_n)
    );

    int passed = 0;
    int total  = 0;

    // Bus write log: {A0, data} captured on every falling edge of write_n
    logic [8:0] wr_log[$];
    logic       prev_wn = 1'b1;
    always @(negedge clk) begin
        if (prev_wn && !write_n) wr_log.push_back({A0, data_out});
        prev_wn <= write_n;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        else passed++;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic run_cfg(input logic [7:0] i1, input logic [7:0] i2, input logic [7:0] i3,
                           input logic [7:0] i4, output int done_at, output int pulses);
        cfg_icw1 = i1; cfg_icw2 = i2; cfg_icw3 = i3; cfg_icw4 = i4;
        cfg_start = 1'b1;
        step();
        cfg_start = 1'b0;
        check("cfg_busy_after_accept", cfg_busy, 1);
        done_at = 0;
        pulses  = 0;
        for (int k = 1; k <= 40; k++) begin
            step();
            if (cfg_done) begin
                pulses++;
                if (done_at == 0) done_at = k;
            end
        end
        $display("cfg icw1=%02h: %0d writes, cfg_done at %0d, pulses %0d", i1, wr_log.size(), done_at, pulses);
    endtask

    typedef struct {
        logic       wr;
        logic       a0;
        logic [7:0] wdata;
        logic [7:0] din;
        logic [7:0] exp_data;
    } vec_t;

    vec_t       tbl[5];
    logic [4:0] wn_bits, cs_bits, oe_bits;
    logic [3:0] rn_bits, rcs_bits, rv_bits;
    logic [5:0] inta_bits, acs_bits;
    logic       no_write;
    int         done_at, pulses;

    initial begin
        tbl[0] = '{wr: 1'b0, a0: 1'b0, wdata: 8'h00, din: 8'h81, exp_data: 8'h81};
        tbl[1] = '{wr: 1'b0, a0: 1'b1, wdata: 8'h00, din: 8'h3C, exp_data: 8'h3C};
        tbl[2] = '{wr: 1'b1, a0: 1'b0, wdata: 8'h0B, din: 8'h00, exp_data: 8'h0B};
        tbl[3] = '{wr: 1'b1, a0: 1'b1, wdata: 8'hFE, din: 8'h00, exp_data: 8'hFE};
        tbl[4] = '{wr: 1'b0, a0: 1'b0, wdata: 8'h00, din: 8'h00, exp_data: 8'h00};

        reset = 1'b1; cfg_start = 1'b0;
        cfg_icw1 = '0; cfg_icw2 = '0; cfg_icw3 = '0; cfg_icw4 = '0;
        reg_wr_req = 1'b0; reg_rd_req = 1'b0; reg_a0 = 1'b0; reg_wr_data = '0;
        INT = 1'b0; int_enable = 1'b1; vec_ready = 1'b0; data_in = '0;
        repeat (3) step();

        // Reset state
        check("rst_strobes", {chip_select_n, write_n, read_n, inta_n}, 4'hF);
        check("rst_data_oe", data_oe, 0);
        check("rst_data_out", data_out, 0);
        check("rst_a0", A0, 0);
        check("rst_cfg", {cfg_busy, cfg_done}, 0);
        check("rst_rd", {reg_rd_valid, reg_rd_data}, 0);
        check("rst_vec", {vec_valid, vec_data}, 0);
        reset = 1'b0;
        step();
        check("rst_reg_ready", reg_ready, 1);

        // Table of single register accesses
        for (int i = 0; i < 5; i++) begin
            reg_a0  = tbl[i].a0;
            data_in = tbl[i].din;
            if (tbl[i].wr) begin
                reg_wr_data = tbl[i].wdata;
                reg_wr_req  = 1'b1;
            end else begin
                reg_rd_req = 1'b1;
            end
            step();
            reg_wr_req = 1'b0;
            reg_rd_req = 1'b0;
            if (tbl[i].wr) begin
                check($sformatf("v%0d_wr_a0", i), A0, tbl[i].a0);
                check($sformatf("v%0d_wr_data", i), data_out, tbl[i].exp_data);
                for (int c = 0; c < 5; c++) begin
                    if (c > 0) step();
                    wn_bits = {wn_bits[3:0], write_n};
                    cs_bits = {cs_bits[3:0], chip_select_n};
                    oe_bits = {oe_bits[3:0], data_oe};
                end
                check($sformatf("v%0d_write_n", i), wn_bits, 5'b10011);
                check($sformatf("v%0d_wr_cs_n", i), cs_bits, 5'b00001);
                check($sformatf("v%0d_data_oe", i), oe_bits, 5'b11110);
                check($sformatf("v%0d_ready_back", i), reg_ready, 1);
                $display("vec %0d write a0=%0d data=%02h", i, tbl[i].a0, tbl[i].wdata);
            end else begin
                for (int c = 0; c < 4; c++) begin
                    if (c > 0) step();
                    rn_bits  = {rn_bits[2:0], read_n};
                    rcs_bits = {rcs_bits[2:0], chip_select_n};
                    rv_bits  = {rv_bits[2:0], reg_rd_valid};
                    if (c == 2) check($sformatf("v%0d_rd_data", i), reg_rd_data, tbl[i].exp_data);
                end
                check($sformatf("v%0d_read_n", i), rn_bits, 4'b0011);
                check($sformatf("v%0d_rd_cs_n", i), rcs_bits, 4'b0011);
                check($sformatf("v%0d_rd_valid", i), rv_bits, 4'b0010);
                $display("vec %0d read a0=%0d data=%02h", i, tbl[i].a0, reg_rd_data);
            end
        end

        // ICW sequence, single mode with IC4: no ICW3 write
        wr_log.delete();
        run_cfg(8'h13, 8'h20, 8'hAA, 8'h01, done_at, pulses);
        check("cfg1_writes", wr_log.size(), 3);
        if (wr_log.size() == 3) begin
            check("cfg1_w0", wr_log[0], 9'h013);
            check("cfg1_w1", wr_log[1], 9'h120);
            check("cfg1_w2", wr_log[2], 9'h101);
        end
        check("cfg1_done_at", done_at, 12);
        check("cfg1_done_pulses", pulses, 1);
        check("cfg1_busy_end", cfg_busy, 0);

        // ICW sequence, cascade mode with IC4: four writes
        wr_log.delete();
        run_cfg(8'h11, 8'h08, 8'h04, 8'h1D, done_at, pulses);
        check("cfg2_writes", wr_log.size(), 4);
        if (wr_log.size() == 4) begin
            check("cfg2_w0", wr_log[0], 9'h011);
            check("cfg2_w1", wr_log[1], 9'h108);
            check("cfg2_w2", wr_log[2], 9'h104);
            check("cfg2_w3", wr_log[3], 9'h11D);
        end
        check("cfg2_done_at", done_at, 16);
        check("cfg2_done_pulses", pulses, 1);

        // INTA cycle: 2 low, 1 high, 2 low, then vector buffered
        INT = 1'b1; data_in = 8'h42;
        step();
        for (int c = 0; c < 6; c++) begin
            if (c > 0) step();
            inta_bits = {inta_bits[4:0], inta_n};
            acs_bits  = {acs_bits[4:0], chip_select_n};
        end
        check("inta_pattern", inta_bits, 6'b001001);
        check("inta_cs_n_high", acs_bits, 6'b111111);
        step();
        check("inta_vec_valid", vec_valid, 1);
        check("inta_vec_data", vec_data, 8'h42);
        $display("inta vector %02h valid=%0d", vec_data, vec_valid);
        for (int c = 0; c < 5; c++) begin
            step();
            check($sformatf("hold%0d_vec_valid", c), vec_valid, 1);
            check($sformatf("hold%0d_no_inta", c), inta_n, 1);
        end
        vec_ready = 1'b1;
        step();
        vec_ready = 1'b0;
        data_in = 8'h55;
        check("consume_clears", vec_valid, 0);
        step();
        check("next_inta_starts", inta_n, 0);
        INT = 1'b0;
        repeat (6) step();
        check("dropped_int_vec_valid", vec_valid, 1);
        check("dropped_int_vec_data", vec_data, 8'h55);
        $display("inta vector %02h after INT dropped", vec_data);
        vec_ready = 1'b1;
        step();
        vec_ready = 1'b0;
        check("consume2_clears", vec_valid, 0);

        // Simultaneous write request and INT: acknowledge first, then the write
        data_in = 8'h99; reg_a0 = 1'b1; reg_wr_data = 8'h5A;
        reg_wr_req = 1'b1; INT = 1'b1;
        step();
        INT = 1'b0;
        check("prio_inta_first", {inta_n, chip_select_n}, 2'b01);
        no_write = 1'b1;
        for (int c = 1; c <= 6; c++) begin
            step();
            if (!write_n || !chip_select_n) no_write = 1'b0;
        end
        check("prio_no_write_during_inta", no_write, 1);
        check("prio_vec", {vec_valid, vec_data}, {1'b1, 8'h99});
        step();
        check("prio_write_cs_n", chip_select_n, 0);
        check("prio_write_addr_data", {A0, data_out}, 9'h15A);
        reg_wr_req = 1'b0;
        $display("prio: vector %02h then write %02h", vec_data, data_out);
        repeat (4) step();
        vec_ready = 1'b1;
        step();
        vec_ready = 1'b0;

        // cfg_start during INTA, then reset in A2
        wr_log.delete();
        cfg_icw1 = 8'h13; cfg_icw2 = 8'h20; cfg_icw3 = 8'h00; cfg_icw4 = 8'h01;
        INT = 1'b1; data_in = 8'h77;
        step();
        cfg_start = 1'b1;
        repeat (3) step();
        check("midA2_inta_low", inta_n, 0);
        reset = 1'b1;
        cfg_start = 1'b0;
        step();
        check("midreset_strobes", {chip_select_n, write_n, read_n, inta_n}, 4'hF);
        check("midreset_vec_valid", vec_valid, 0);
        check("midreset_cfg_busy", cfg_busy, 0);
        reset = 1'b0;
        INT = 1'b0;
        repeat (20) step();
        check("midreset_no_write", wr_log.size(), 0);
        check("midreset_idle_ready", reg_ready, 1);
        $display("reset mid-A2: writes=%0d busy=%0d", wr_log.size(), cfg_busy);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/pic_host_bus_controller.md
# pic_host_bus_controller

CPU-side counterpart to the 8259 PIC: drives the PIC's chip-select, A0, read/write strobes and INTA, and sits between a simple on-chip request interface and the PIC pins. It runs the ICW initialization sequence from a single command, performs single OCW/status register accesses, and answers INT with the two-pulse INTA acknowledge cycle. The vector read on the second pulse goes out through a valid/ready buffer. In testbenches it replaces the 8086 host model; in integrated designs it is the PIC's bus master.

## Interface

Parameters:
- STROBE_CYCLES, 2: low width, in clk cycles, of every write_n, read_n and inta_n pulse (legal values ≥1).
- GAP_CYCLES, 1: high time of inta_n between the first and second INTA pulse (legal values ≥1).

Ports:
- clk  in  1  single clock; all logic is rising-edge.
- reset  in  1  synchronous, active-high.
- cfg_start  in  1  one-cycle request to run the ICW sequence.
- cfg_icw1, cfg_icw2, cfg_icw3, cfg_icw4  in  8 each  ICW values, sampled when cfg_start is accepted.
- cfg_busy  out  1  high from cfg_start acceptance until cfg_done.
- cfg_done  out  1  one-cycle pulse after the final ICW hold cycle.
- reg_wr_req / reg_rd_req  in  1  single OCW write or status read request.
- reg_a0  in  1  A0 for the access.
- reg_wr_data  in  8  OCW value.
- reg_ready  out  1  a request is accepted when (reg_wr_req|reg_rd_req) && reg_ready.
- reg_rd_data  out  8  captured read data.
- reg_rd_valid  out  1  one-cycle pulse when reg_rd_data is updated.
- INT  in  1  interrupt line from the PIC.
- int_enable  in  1  allows acknowledge cycles.
- vec_data  out  8  captured vector.
- vec_valid  out  1  vector buffer full.
- vec_ready  in  1  consumer accepts the vector.
- data_in  in  8  PIC data bus, read side.
- data_out  out  8  PIC data bus, drive side.
- data_oe  out  1  bus drive enable.
- A0  out  1  PIC address line.
- chip_select_n, write_n, read_n, inta_n  out  1 each  active-low PIC strobes.

## Operation

- FSM states: IDLE, W_SETUP, W_STROBE, W_HOLD, R_STROBE, R_RECOV, A1, AGAP, A2, A_DONE. One down-counter is shared by the strobe and gap phases.
- Arbitration happens in IDLE only, with fixed priority:
  1. cfg_start
  2. INTA cycle (INT && int_enable && !vec_valid)
  3. reg read/write; a write wins if both requests are asserted.
- reg_ready = IDLE && !cfg_start && !(INT && int_enable && !vec_valid).
- ICW sequence writes, in order:
  - ICW1 with A0=0.
  - ICW2 with A0=1.
  - ICW3 with A0=1, only if icw1[1]==0 (cascade mode).
  - ICW4 with A0=1, only if icw1[0]==1 (IC4).
- Writes in the ICW sequence are back-to-back. No INTA or reg access is interleaved, and INT is ignored while cfg_busy is high. cfg_start while busy is ignored.
- Write cycle timing:
  - W_SETUP, 1 cycle: chip_select_n=0, A0 and data_out valid, data_oe=1.
  - W_STROBE, STROBE_CYCLES cycles: write_n=0.
  - W_HOLD, 1 cycle: write_n=1, data still driven.
  - Then chip_select_n=1 and data_oe=0.
- Read cycle timing:
  - R_STROBE, STROBE_CYCLES cycles: chip_select_n=0, read_n=0, data_oe=0. data_in is sampled on the last strobe cycle.
  - R_RECOV, 1 cycle: strobes high, reg_rd_valid pulses.
- INTA cycle timing (chip_select_n stays 1):
  - A1: inta_n=0 for STROBE_CYCLES.
  - AGAP: inta_n=1 for GAP_CYCLES.
  - A2: inta_n=0 for STROBE_CYCLES; data_in is sampled on the last cycle into vec_data.
  - A_DONE, 1 cycle: vec_valid set.
- Once started, an INTA cycle always completes, even if INT drops. The vector captured in that case is delivered as-is.
- Vector buffer: vec_valid stays high until vec_valid && vec_ready; it clears on that edge. vec_data is stable while vec_valid is high. No new INTA cycle starts while the buffer is full.

## Timing

- Reset values: chip_select_n, write_n, read_n and inta_n = 1; data_oe=0; data_out=0; A0=0; cfg_busy=0; cfg_done=0; reg_rd_valid=0; vec_valid=0; vec_data=0; reg_rd_data=0; state=IDLE.
- Reset mid-operation forces all strobes high on the next edge; no partial cycle resumes.
- Latencies at the defaults (S=2, G=1), counted from the acceptance edge:
  - Write: S+2 = 4 cycles bus-active; reg_ready returns in the following cycle.
  - Read: reg_rd_valid at cycle S+1 = 3.
  - INTA: inta_n falls in the cycle after the request is seen; vec_valid rises 2S+G+1 = 6 cycles later.
- Every strobe and select output is registered, so no output glitches.

## Test plan

- ICW1=0x13, ICW2=0x20, ICW4=0x01 (single mode, IC4) → exactly 3 writes with A0 values 0,1,1 and data 13,20,01. No ICW3 write. cfg_done pulses once 12 cycles after acceptance.
- ICW1=0x11 (cascade), ICW3=0x04 → 4 writes; the third is 0x04 with A0=1.
- INT=1, int_enable=1, data_in=0x42 during A2 → inta_n is low 2 cycles, high 1 cycle, low 2 cycles. vec_valid=1 with vec_data=0x42. vec_valid is held through 5 cycles of vec_ready=0 and cleared on the first vec_ready=1.
- INT held high with vec_valid=1 → no further inta_n pulse until the vector is consumed. The next cycle then starts within 1 cycle.
- reg_rd_req with A0=0 and data_in=0x81 → read_n is low 2 cycles and reg_rd_valid pulses with 0x81. Simultaneous reg_wr_req and INT → the INTA cycle runs first, then the write.
- cfg_start during INTA, then reset asserted mid-A2 → all strobes are high on the next edge, vec_valid=0 and cfg_busy=0, and no write occurs.
